// File: rtl/deserializer_pkg.sv
// Shared constants, state type and bit-count helper for the deserializer and its benches.
// mod encoding: 0 stands for a full DATA_W-bit word, otherwise the literal bit count.
package deserializer_pkg;

    localparam int DATA_W    = 16;
    localparam int MIN_FRAME = 3;
    localparam int MOD_W     = $clog2(DATA_W);
    localparam int CNT_W     = MOD_W + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] mod_to_len(input logic [MOD_W-1:0] mod);
        if (mod == '0)
            return CNT_W'(DATA_W);
        else
            return {1'b0, mod};
    endfunction

endpackage

// File: rtl/deserializer.sv
// Collects an MSB-first serial stream into left-aligned DATA_W-bit words with a bit count.
// Latency: word valid 1 cycle after the DATA_W-th bit or after the first idle cycle of a gap.
// Backpressure: none; deser_data_val_o and short_frame_o are fire-and-forget pulses.
module deserializer
    import deserializer_pkg::*;
(
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              short_frame_o
);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    logic [MOD_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg_ins;
    logic              last_bit;
    logic              long_enough;

    // In COLLECT cnt is 1..DATA_W-1, so the low MOD_W bits address the next slot.
    always_comb begin
        bit_idx            = MOD_W'(DATA_W - 1) - cnt[MOD_W-1:0];
        shreg_ins          = shreg;
        shreg_ins[bit_idx] = ser_data_i;
        last_bit           = (cnt == CNT_W'(DATA_W - 1));
        long_enough        = (cnt >= CNT_W'(MIN_FRAME));
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state            <= IDLE;
            shreg            <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            short_frame_o    <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            short_frame_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ser_data_val_i) begin
                        shreg <= {ser_data_i, {(DATA_W-1){1'b0}}};
                        cnt   <= CNT_W'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (ser_data_val_i) begin
                        if (last_bit) begin
                            // Full word: emit now so a bit on the very next cycle opens a new frame.
                            deser_data_o     <= shreg_ins;
                            deser_data_mod_o <= '0;
                            deser_data_val_o <= 1'b1;
                            shreg            <= '0;
                            cnt              <= '0;
                            state            <= IDLE;
                        end else begin
                            shreg <= shreg_ins;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end else begin
                        if (long_enough) begin
                            deser_data_o     <= shreg;
                            deser_data_mod_o <= cnt[MOD_W-1:0];
                            deser_data_val_o <= 1'b1;
                        end else begin
                            short_frame_o <= 1'b1;
                        end
                        shreg <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    shreg <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: queue-based frame model checked every cycle, plus directed literal checks.
module tb_deserializer;
    import deserializer_pkg::*;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        ser_data_i = 1'b0;
    logic        ser_data_val_i = 1'b0;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;
    logic        short_frame_o;

    always #5 clk_i = ~clk_i;

    deserializer dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .short_frame_o    (short_frame_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the frame is simply the list of bits received so far.
    bit          mq[$];
    logic [15:0] e_data = '0;
    logic [3:0]  e_mod = '0;
    logic        e_val = 1'b0;
    logic        e_short = 1'b0;
    bit          chk_en = 1'b0;

    function automatic logic [15:0] pack_bits();
        logic [15:0] w = '0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i]) w = w | (16'h8000 >> i);
        return w;
    endfunction

    always @(posedge clk_i) begin
        cyc++;
        e_val   = 1'b0;
        e_short = 1'b0;
        if (srst_i) begin
            mq.delete();
            e_data = '0;
            e_mod  = '0;
            chk_en = 1'b1;
        end else if (ser_data_val_i) begin
            mq.push_back(ser_data_i);
            if (mq.size() == 16) begin
                e_data = pack_bits();
                e_mod  = 4'd0;
                e_val  = 1'b1;
                mq.delete();
            end
        end else if (mq.size() > 0) begin
            if (mq.size() >= 3) begin
                e_data = pack_bits();
                e_mod  = 4'(mq.size());
                e_val  = 1'b1;
            end else begin
                e_short = 1'b1;
            end
            mq.delete();
        end
    end

    // Pulse log for the directed checks.
    logic [15:0] p_data[$];
    logic [3:0]  p_mod[$];
    int          p_cyc[$];
    int          short_seen = 0;

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cyc_data", 32'(deser_data_o), 32'(e_data));
            check("cyc_mod", 32'(deser_data_mod_o), 32'(e_mod));
            check("cyc_val", 32'(deser_data_val_o), 32'(e_val));
            check("cyc_short", 32'(short_frame_o), 32'(e_short));
            if (deser_data_val_o === 1'b1) begin
                p_data.push_back(deser_data_o);
                p_mod.push_back(deser_data_mod_o);
                p_cyc.push_back(cyc);
            end
            if (short_frame_o === 1'b1) short_seen++;
        end
    end

    task automatic clr_log();
        p_data.delete();
        p_mod.delete();
        p_cyc.delete();
        short_seen = 0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            ser_data_val_i = 1'b1;
            ser_data_i     = w[15-i];
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            ser_data_val_i = 1'b0;
            ser_data_i     = 1'($urandom);
        end
    endtask

    logic [15:0] exp_w[$];
    logic [3:0]  exp_m[$];

    initial begin
        repeat (3) @(negedge clk_i);
        srst_i = 1'b0;
        @(negedge clk_i);
        check("reset_data", 32'(deser_data_o), 32'h0);
        check("reset_mod", 32'(deser_data_mod_o), 32'h0);
        check("reset_val", 32'(deser_data_val_o), 32'h0);
        check("reset_short", 32'(short_frame_o), 32'h0);

        // Full 16-bit frame followed by a gap: exactly one pulse.
        clr_log();
        send_bits(16'hA5C3, 16);
        gap(4);
        check("full_count", 32'(p_data.size()), 32'd1);
        if (p_data.size() == 1) begin
            check("full_data", 32'(p_data[0]), 32'h0000A5C3);
            check("full_mod", 32'(p_mod[0]), 32'd0);
        end

        // 5-bit gap-terminated frame.
        clr_log();
        send_bits(16'hB000, 5);
        gap(3);
        check("five_count", 32'(p_data.size()), 32'd1);
        if (p_data.size() == 1) begin
            check("five_data", 32'(p_data[0]), 32'h0000B000);
            check("five_mod", 32'(p_mod[0]), 32'd5);
        end

        // Runs of 2 and 1 bits are dropped with a short-frame pulse.
        for (int n = 2; n >= 1; n--) begin
            clr_log();
            send_bits(16'hC000, n);
            gap(3);
            check("short_pulses", 32'(short_seen), 32'd1);
            check("short_no_val", 32'(p_data.size()), 32'd0);
            check("short_hold_data", 32'(deser_data_o), 32'h0000B000);
            check("short_hold_mod", 32'(deser_data_mod_o), 32'd5);
        end

        // Back-to-back full frames with valid held high.
        clr_log();
        send_bits(16'h1234, 16);
        send_bits(16'hFFFF, 16);
        gap(3);
        check("b2b_count", 32'(p_data.size()), 32'd2);
        if (p_data.size() == 2) begin
            check("b2b_data0", 32'(p_data[0]), 32'h00001234);
            check("b2b_data1", 32'(p_data[1]), 32'h0000FFFF);
            check("b2b_mod0", 32'(p_mod[0]), 32'd0);
            check("b2b_mod1", 32'(p_mod[1]), 32'd0);
            check("b2b_spacing", 32'(p_cyc[1] - p_cyc[0]), 32'd16);
        end

        // Reset mid-frame discards the partial frame.
        clr_log();
        send_bits(16'h5A5A, 9);
        @(negedge clk_i);
        srst_i         = 1'b1;
        ser_data_val_i = 1'b0;
        @(negedge clk_i);
        srst_i = 1'b0;
        check("rst_abort_short", 32'(short_seen), 32'd0);
        send_bits(16'hE000, 3);
        gap(3);
        check("rst_count", 32'(p_data.size()), 32'd1);
        if (p_data.size() == 1) begin
            check("rst_data", 32'(p_data[0]), 32'h0000E000);
            check("rst_mod", 32'(p_mod[0]), 32'd3);
        end

        // Loopback-style random traffic: mod 0 or 3..15, left-aligned words.
        clr_log();
        for (int it = 0; it < 1000; it++) begin
            int          m;
            int          len;
            logic [15:0] w;
            logic [15:0] mask;
            m    = $urandom_range(0, 13);
            m    = (m == 0) ? 0 : m + 2;
            len  = (m == 0) ? 16 : m;
            mask = 16'hFFFF << (16 - len);
            w    = 16'($urandom) & mask;
            exp_w.push_back(w);
            exp_m.push_back(4'(m));
            send_bits(w, len);
            if (m != 0 || $urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
        end
        gap(3);
        check("loop_count", 32'(p_data.size()), 32'd1000);
        for (int i = 0; i < 1000 && i < p_data.size(); i++) begin
            check("loop_data", 32'(p_data[i]), 32'(exp_w[i]));
            check("loop_mod", 32'(p_mod[i]), 32'(exp_m[i]));
        end
        check("loop_short", 32'(short_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
